spike_count_decoder: RTL and testbench
======================================

Name: spike_count_decoder

Overview:
- Output-side decoder for the IF spiking network.
- Counts spikes on each network output line over a fixed observation window, then finds the most active neuron (argmax).
- Returns the winning index and its count to the control logic through a valid/ready handshake.
- Sits directly after if_network; its spike_in is driven by the network's spike_out.

Parameters:
- NUM_OUTPUTS, 4, number of spike lines (network output neurons) observed.
- WINDOW, 64, observation window length in clock cycles (>=1).
- COUNT_WIDTH, 8, width of each per-neuron spike counter.
- EARLY_THRESH, 32, count that ends the window early (used only with the optional feature).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a window; honoured only in IDLE.
- spike_in  input  NUM_OUTPUTS  spike lines from the network, sampled every COUNT cycle.
- busy  output  1  high in COUNT and SCAN.
- result_valid  output  1  result available; held until accepted.
- result_ready  input  1  consumer accepts the result.
- winner  output  clog2(NUM_OUTPUTS) (min 1)  index of the neuron with the highest count.
- winner_count  output  COUNT_WIDTH  spike count of the winner.
- silent  output  1  all counts were zero.
- tie  output  1  another neuron equalled the winning count (count > 0).

Behaviour:
- Reset: state=IDLE; all counters, window timer and scan index = 0; busy=0, result_valid=0, winner=0, winner_count=0, silent=0, tie=0.
- Reset asserted mid-window or mid-scan aborts immediately; no partial result is emitted.
- Reset has priority over every other event.
- FSM states: IDLE, COUNT, SCAN, DONE.
- IDLE:
  - start=1 clears all counters and the timer; next state is COUNT.
  - start in any other state is ignored; it is not queued.
- COUNT:
  - Lasts exactly WINDOW cycles.
  - Each cycle, counter[i] increments when spike_in[i]=1.
  - Counters saturate at 2^COUNT_WIDTH-1; they never wrap.
  - After the WINDOW-th COUNT cycle, next state is SCAN.
  - Spikes arriving outside COUNT are ignored.
- SCAN:
  - Sequential argmax, one counter per cycle, index 0..NUM_OUTPUTS-1, so SCAN lasts NUM_OUTPUTS cycles.
  - The running max is replaced only when a counter is strictly greater, so the lowest index wins a tie.
  - tie is set when a counter equals the running max and max > 0; tie clears when a strictly greater value replaces the max.
  - After the last index, next state is DONE.
- DONE:
  - result_valid=1; winner, winner_count, silent and tie are stable.
  - When result_valid && result_ready, next state is IDLE and result_valid drops the following cycle.
  - Outputs keep their last values in IDLE until the next start.
- Latency: start sampled at cycle t gives COUNT cycles t+1..t+WINDOW, SCAN cycles t+WINDOW+1..t+WINDOW+NUM_OUTPUTS, and result_valid=1 from cycle t+WINDOW+NUM_OUTPUTS+1.
- All counts zero: winner=0, winner_count=0, silent=1, tie=0.
- result_ready high before DONE has no effect.
- start together with the result handshake in DONE is ignored; start must be re-issued in IDLE.

Optional Feature:
- Macro SPIKE_DECODER_EARLY_EXIT_EN.
- Defined:
  - During COUNT, if any counter's next value is >= EARLY_THRESH, COUNT ends after that cycle (that cycle's spikes included) and SCAN follows.
  - Extra output early_exit (1 bit, reset 0) is set in DONE when the window ended early; it clears on the next start.
- Not defined: the window always lasts WINDOW cycles, EARLY_THRESH is unused, and the early_exit port does not exist.

Test Plan:
- WINDOW=16, spike_in=4'b0100 held constant, start pulse, result_ready=1 -> result_valid at start+21; winner=2, winner_count=16, silent=0, tie=0.
- spike_in=4'b0000 for the full window -> winner=0, winner_count=0, silent=1, tie=0.
- spike_in=4'b1010 constant, WINDOW=16 -> winner=1, winner_count=16, tie=1.
- COUNT_WIDTH=4, WINDOW=64, spike_in[0]=1 constant -> winner_count=15 (saturated), winner=0.
- Reset pulse 5 cycles into COUNT, then a fresh start with spike_in=4'b0001 -> no result_valid before the new window; final winner=0, count=16.
- result_ready=0 for 10 cycles in DONE -> result_valid and outputs stable throughout; start pulses in DONE ignored; IDLE one cycle after ready=1.
- With SPIKE_DECODER_EARLY_EXIT_EN, EARLY_THRESH=8, WINDOW=64, spike_in=4'b1000 -> result_valid at start+13; winner=3, winner_count=8, early_exit=1.

Source files
------------

// File: rtl/spike_count_decoder.sv
// Output-side decoder for the IF network: counts spikes per line over a window, then runs a sequential argmax.
// Define SPIKE_DECODER_EARLY_EXIT_EN to end the window once any count reaches EARLY_THRESH (adds early_exit).
`timescale 1ns/1ps
module spike_count_decoder #(
   parameter int NUM_OUTPUTS  = 4,
   parameter int WINDOW       = 64,
   parameter int COUNT_WIDTH  = 8,
   parameter int EARLY_THRESH = 32,
   localparam int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_OUTPUTS-1:0] spike_in,
   output logic                   busy,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [IDX_W-1:0]       winner,
   output logic [COUNT_WIDTH-1:0] winner_count,
   output logic                   silent,
   output logic                   tie
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
   ,
   output logic                   early_exit
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_SCAN, ST_DONE} state_t;

   localparam int TMR_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
   localparam logic [TMR_W-1:0]       TMR_ZERO = {TMR_W{1'b0}};
   localparam logic [TMR_W-1:0]       TMR_ONE  = TMR_W'(1);
   localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(WINDOW - 1);
   localparam logic [IDX_W-1:0]       IDX_ZERO = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]       IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
   localparam logic EARLY_EN = 1'b1;
`else
   localparam logic EARLY_EN = 1'b0;
`endif

   state_t                   state_q;
   logic [COUNT_WIDTH-1:0]   cnt_q [NUM_OUTPUTS];
   logic [COUNT_WIDTH-1:0]   cnt_d [NUM_OUTPUTS];
   logic [NUM_OUTPUTS-1:0]   over_s;
   logic                     thresh_hit_s;
   logic                     window_end_s;
   logic [TMR_W-1:0]         timer_q;
   logic [IDX_W-1:0]         scan_idx_q;
   logic [COUNT_WIDTH-1:0]   scan_cur_s;
   logic [COUNT_WIDTH-1:0]   run_max_q, run_max_d;
   logic [IDX_W-1:0]         run_idx_q, run_idx_d;
   logic                     run_tie_q, run_tie_d;
   logic                     busy_q, valid_q, silent_q, tie_q;
   logic [IDX_W-1:0]         winner_q;
   logic [COUNT_WIDTH-1:0]   winner_count_q;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
   logic                     early_seen_q, early_exit_q;
`endif

   // Saturating next counts and the early-exit threshold test on those next counts.
   always_comb begin
      over_s = {NUM_OUTPUTS{1'b0}};
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
         if (spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else begin
            cnt_d[i] = cnt_q[i];
         end
         over_s[i] = (int'(cnt_d[i]) >= EARLY_THRESH);
      end
      thresh_hit_s = EARLY_EN && (|over_s);
      window_end_s = (timer_q == TMR_LAST) || thresh_hit_s;
   end

   // One argmax step: strictly greater replaces (lowest index wins), equal non-zero flags a tie.
   always_comb begin
      scan_cur_s = cnt_q[scan_idx_q];
      run_max_d  = run_max_q;
      run_idx_d  = run_idx_q;
      run_tie_d  = run_tie_q;
      if (scan_cur_s > run_max_q) begin
         run_max_d = scan_cur_s;
         run_idx_d = scan_idx_q;
         run_tie_d = 1'b0;
      end else if ((scan_cur_s == run_max_q) && (run_max_q != CNT_ZERO)) begin
         run_tie_d = 1'b1;
      end else begin
         run_tie_d = run_tie_q;
      end
   end

   // Control FSM with all state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= CNT_ZERO;
         timer_q        <= TMR_ZERO;
         scan_idx_q     <= IDX_ZERO;
         run_max_q      <= CNT_ZERO;
         run_idx_q      <= IDX_ZERO;
         run_tie_q      <= 1'b0;
         busy_q         <= 1'b0;
         valid_q        <= 1'b0;
         winner_q       <= IDX_ZERO;
         winner_count_q <= CNT_ZERO;
         silent_q       <= 1'b0;
         tie_q          <= 1'b0;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
         early_seen_q   <= 1'b0;
         early_exit_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= CNT_ZERO;
                  timer_q <= TMR_ZERO;
                  busy_q  <= 1'b1;
                  state_q <= ST_COUNT;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
                  early_seen_q <= 1'b0;
                  early_exit_q <= 1'b0;
`endif
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_COUNT: begin
               for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= cnt_d[i];
               timer_q <= timer_q + TMR_ONE;
               if (window_end_s) begin
                  scan_idx_q <= IDX_ZERO;
                  run_max_q  <= CNT_ZERO;
                  run_idx_q  <= IDX_ZERO;
                  run_tie_q  <= 1'b0;
                  state_q    <= ST_SCAN;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
                  early_seen_q <= thresh_hit_s && (timer_q != TMR_LAST);
`endif
               end else begin
                  state_q <= ST_COUNT;
               end
            end
            ST_SCAN: begin
               run_max_q  <= run_max_d;
               run_idx_q  <= run_idx_d;
               run_tie_q  <= run_tie_d;
               scan_idx_q <= scan_idx_q + IDX_ONE;
               if (scan_idx_q == IDX_LAST) begin
                  winner_q       <= run_idx_d;
                  winner_count_q <= run_max_d;
                  silent_q       <= (run_max_d == CNT_ZERO);
                  tie_q          <= run_tie_d;
                  busy_q         <= 1'b0;
                  valid_q        <= 1'b1;
                  state_q        <= ST_DONE;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
                  early_exit_q   <= early_seen_q;
`endif
               end else begin
                  state_q <= ST_SCAN;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign result_valid = valid_q;
   assign winner       = winner_q;
   assign winner_count = winner_count_q;
   assign silent       = silent_q;
   assign tie          = tie_q;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
   assign early_exit   = early_exit_q;
`endif

endmodule

// File: tb/tb_spike_count_decoder.sv
// Bench for spike_count_decoder: two instances (unsaturated and saturating) checked against a count/argmax model.
`timescale 1ns/1ps
module tb_spike_count_decoder;

   localparam int N   = 4;
   localparam int WA  = 16;
   localparam int CWA = 8;
   localparam int THA = 32;
   localparam int WS  = 64;
   localparam int CWS = 4;
   localparam int THS = 8;
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, sel, start_v, ready_v;
   logic [3:0] spike_v;

   logic       a_start, a_ready, a_busy, a_valid, a_silent, a_tie, a_early;
   logic [3:0] a_spike;
   logic [1:0] a_winner;
   logic [7:0] a_count;
   logic       s_start, s_ready, s_busy, s_valid, s_silent, s_tie, s_early;
   logic [3:0] s_spike;
   logic [1:0] s_winner;
   logic [3:0] s_count;

   assign a_start = sel ? 1'b0 : start_v;
   assign a_ready = sel ? 1'b0 : ready_v;
   assign a_spike = sel ? 4'b0000 : spike_v;
   assign s_start = sel ? start_v : 1'b0;
   assign s_ready = sel ? ready_v : 1'b0;
   assign s_spike = sel ? spike_v : 4'b0000;
`ifndef SPIKE_DECODER_EARLY_EXIT_EN
   assign a_early = 1'b0;
   assign s_early = 1'b0;
`endif

   logic       c_busy, c_valid, c_silent, c_tie, c_early;
   logic [1:0] c_winner;
   logic [7:0] c_count;
   assign c_busy   = sel ? s_busy   : a_busy;
   assign c_valid  = sel ? s_valid  : a_valid;
   assign c_silent = sel ? s_silent : a_silent;
   assign c_tie    = sel ? s_tie    : a_tie;
   assign c_early  = sel ? s_early  : a_early;
   assign c_winner = sel ? s_winner : a_winner;
   assign c_count  = sel ? {4'b0000, s_count} : a_count;

   spike_count_decoder #(.NUM_OUTPUTS(N), .WINDOW(WA), .COUNT_WIDTH(CWA), .EARLY_THRESH(THA)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .spike_in(a_spike), .busy(a_busy),
      .result_valid(a_valid), .result_ready(a_ready), .winner(a_winner),
      .winner_count(a_count), .silent(a_silent), .tie(a_tie)
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
      , .early_exit(a_early)
`endif
   );

   spike_count_decoder #(.NUM_OUTPUTS(N), .WINDOW(WS), .COUNT_WIDTH(CWS), .EARLY_THRESH(THS)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .spike_in(s_spike), .busy(s_busy),
      .result_valid(s_valid), .result_ready(s_ready), .winner(s_winner),
      .winner_count(s_count), .silent(s_silent), .tie(s_tie)
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
      , .early_exit(s_early)
`endif
   );

   int         total = 0;
   int         bad   = 0;
   logic [3:0] vecs [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: per-line spike totals (saturated), optional early stop, then argmax with lowest-index priority.
   task automatic model(input int win, input int cw, input int th, output int ew, output int ec,
                        output bit es, output bit et, output int ncyc, output bit eearly);
      int cnt [N];
      int maxv, neq;
      bit stop;
      maxv = (1 << cw) - 1;
      stop = 1'b0;
      ncyc = win;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int c = 0; c < win; c++) begin
         if (!stop) begin
            for (int i = 0; i < N; i++) if (vecs[c][i]) cnt[i] = (cnt[i] < maxv) ? cnt[i] + 1 : maxv;
            for (int i = 0; i < N; i++) if (EARLY && cnt[i] >= th) stop = 1'b1;
            if (stop) ncyc = c + 1;
         end
      end
      ec = 0; ew = 0; neq = 0;
      for (int i = 0; i < N; i++) if (cnt[i] > ec) begin ec = cnt[i]; ew = i; end
      for (int i = 0; i < N; i++) if (cnt[i] == ec) neq++;
      es = (ec == 0);
      et = (ec > 0) && (neq > 1);
      eearly = (ncyc < win);
   endtask

   task automatic fill_const(input logic [3:0] p);
      for (int c = 0; c < 64; c++) vecs[c] = p;
   endtask

   task automatic fill_rand();
      int dens [N];
      for (int i = 0; i < N; i++) dens[i] = $urandom_range(0, 100);
      for (int c = 0; c < 64; c++)
         for (int i = 0; i < N; i++) vecs[c][i] = ($urandom_range(0, 99) < dens[i]);
   endtask

   task automatic run(input bit s, input int hold, input bit early_ready, input string tag);
      int win, ew, ec, ncyc, lat;
      bit es, et, eearly, found;
      win = s ? WS : WA;
      model(win, s ? CWS : CWA, s ? THS : THA, ew, ec, es, et, ncyc, eearly);
      @(negedge clk);
      sel = s; start_v = 1'b1; ready_v = early_ready; spike_v = 4'($urandom);
      found = 1'b0; lat = 0;
      for (int k = 1; k <= 200 && !found; k++) begin
         @(negedge clk);
         if (k == 1 || k == 4) start_v = 1'b0;
         if (k == 3) start_v = 1'b1;
         if (k == 1) chk({tag, ".busy_count"}, c_busy, 1'b1);
         if (c_valid === 1'b1) begin
            found = 1'b1; lat = k;
         end else begin
            spike_v = (k <= win) ? vecs[k-1] : 4'($urandom);
         end
      end
      chk({tag, ".latency"}, lat, ncyc + N + 1);
      if (!found) begin
         rst = 1'b1; @(negedge clk); rst = 1'b0;
         return;
      end
      chk({tag, ".winner"}, c_winner, ew);
      chk({tag, ".count"}, c_count, ec);
      chk({tag, ".silent"}, c_silent, es);
      chk({tag, ".tie"}, c_tie, et);
      chk({tag, ".busy_done"}, c_busy, 1'b0);
`ifdef SPIKE_DECODER_EARLY_EXIT_EN
      chk({tag, ".early"}, c_early, eearly);
`endif
      if (early_ready) begin
         @(negedge clk);
         chk({tag, ".valid_drop"}, c_valid, 1'b0);
         ready_v = 1'b0;
      end else begin
         for (int h = 0; h < hold; h++) begin
            start_v = h[0];
            @(negedge clk);
            chk({tag, ".hold_valid"}, c_valid, 1'b1);
            chk({tag, ".hold_count"}, c_count, ec);
         end
         start_v = 1'b1; ready_v = 1'b1;
         @(negedge clk);
         start_v = 1'b0; ready_v = 1'b0;
         chk({tag, ".valid_drop"}, c_valid, 1'b0);
         chk({tag, ".busy_idle"}, c_busy, 1'b0);
         @(negedge clk);
         chk({tag, ".start_ignored"}, c_busy, 1'b0);
         chk({tag, ".idle_winner"}, c_winner, ew);
      end
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; start_v = 1'b0; ready_v = 1'b0; spike_v = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rst.a_valid", a_valid, 1'b0);
      chk("rst.a_busy", a_busy, 1'b0);
      chk("rst.a_winner", a_winner, 2'd0);
      chk("rst.a_count", a_count, 8'd0);
      chk("rst.a_flags", {a_silent, a_tie, a_early}, 3'b000);
      chk("rst.s_state", {s_valid, s_busy, s_silent, s_tie, s_early}, 5'b00000);
      chk("rst.s_result", {s_winner, s_count}, 6'd0);
      rst = 1'b0;

      fill_const(4'b0100); run(1'b0, 0, 1'b1, "one_line");
      fill_const(4'b0000); run(1'b0, 2, 1'b0, "silent");
      fill_const(4'b1010); run(1'b0, 3, 1'b0, "tie");
      fill_const(4'b0001); run(1'b1, 1, 1'b0, "saturate");
      fill_const(4'b1000); run(1'b1, 0, 1'b1, "line3_s");

      // Abort a window with reset, then a clean window must follow.
      @(negedge clk);
      sel = 1'b0; start_v = 1'b1;
      @(negedge clk);
      start_v = 1'b0; spike_v = 4'b1111;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.busy", a_busy, 1'b0);
      chk("abort.valid", a_valid, 1'b0);
      chk("abort.result", {a_winner, a_count, a_silent, a_tie}, 12'd0);
      repeat (25) @(negedge clk);
      chk("abort.no_result", a_valid, 1'b0);
      fill_const(4'b0001); run(1'b0, 1, 1'b0, "after_abort");

      fill_const(4'b0100); run(1'b0, 10, 1'b0, "long_hold");

      for (int r = 0; r < 8; r++) begin
         fill_rand();
         run((r % 4) == 3, $urandom_range(0, 3), $urandom_range(0, 1), $sformatf("rand%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
